// File: rtl/sort_sequencer_pkg.sv
// sort_sequencer_pkg: shared vector geometry for the sort sequencer slice
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 8
`endif
package sort_sequencer_pkg;
  localparam int DEF_ARRAYWIDTH = `ARRAYWIDTH;
  localparam int DEF_DATASIZE = `OUTPUT_BUF_DATASIZE;
  localparam int DEF_CNTW = 16;
endpackage

// File: rtl/sort_sequencer_if.sv
// sort_sequencer_if: request and result valid/ready channels of the sequencer
interface sort_sequencer_if
  import sort_sequencer_pkg::*;
#(
  parameter int ARRAYWIDTH = DEF_ARRAYWIDTH,
  parameter int DATASIZE = DEF_DATASIZE
);
  logic req_valid;
  logic req_ready;
  logic [ARRAYWIDTH*DATASIZE-1:0] req_data;
  logic res_valid;
  logic res_ready;
  logic [DATASIZE-1:0] res_max;
  modport master (output req_valid, req_data, res_ready, input req_ready, res_valid, res_max);
  modport slave (input req_valid, req_data, res_ready, output req_ready, res_valid, res_max);
endinterface

// File: rtl/sort_phase_counter.sv
// sort_phase_counter: clearable up-counter with terminal-count compare against a run-time limit
module sort_phase_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  assign tc = cnt == limit;
  // clear wins over increment so a phase boundary restarts from zero
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/sort_sequencer.sv
// sort_sequencer: runs one sorter job at a time and hands back the captured maximum
module sort_sequencer
  import sort_sequencer_pkg::*;
#(
  parameter int ARRAYWIDTH = DEF_ARRAYWIDTH,
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int SORT_CYCLES = ARRAYWIDTH + 1,
  parameter int SETTLE = 2,
  parameter int CNTW = DEF_CNTW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  sort_sequencer_if.slave                bus,
  output logic                           sort_en,
  output logic [ARRAYWIDTH*DATASIZE-1:0] sort_in,
  input  logic [DATASIZE-1:0]            sort_max,
  output logic                           busy,
  output logic [CNTW-1:0]                job_cnt
);
  localparam int CW = $clog2((SORT_CYCLES > SETTLE ? SORT_CYCLES : SETTLE) + 1);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SETTLE, ST_HOLD} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic tc;
  logic accept;
  logic inc;
  if (SORT_CYCLES < 1 || SETTLE < 1) begin : g_bad_cfg
    $error("sort_sequencer: SORT_CYCLES and SETTLE must both be at least 1");
  end
  assign bus.req_ready = state == ST_IDLE && !flush;
  assign busy = state != ST_IDLE;
  assign accept = bus.req_ready && bus.req_valid;
  assign inc = state == ST_RUN || state == ST_SETTLE;
  sort_phase_counter #(.CW(CW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(flush || accept || (inc && tc)),
    .inc(inc),
    .limit(state == ST_RUN ? CW'(SORT_CYCLES - 1) : CW'(SETTLE - 1)),
    .cnt(cnt),
    .tc(tc)
  );
  // job FSM: load, hold sorter enable for the phase count, settle, present result
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sort_en <= 1'b0;
      sort_in <= '0;
      bus.res_valid <= 1'b0;
      bus.res_max <= '0;
      job_cnt <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      sort_en <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.req_valid) begin
          sort_in <= bus.req_data;
          sort_en <= 1'b1;
          state <= ST_RUN;
        end
        ST_RUN: if (tc) begin
          sort_en <= 1'b0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: if (tc) begin
          bus.res_max <= sort_max;
          bus.res_valid <= 1'b1;
          state <= ST_HOLD;
        end
        default: if (bus.res_ready) begin
          bus.res_valid <= 1'b0;
          job_cnt <= job_cnt + 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sort_sequencer.sv
// tb_sort_sequencer: directed checks of the sort sequencer with a behavioural sorter stand-in
module tb_sort_sequencer;
  import sort_sequencer_pkg::*;
  localparam int AW = DEF_ARRAYWIDTH;
  localparam int DW = DEF_DATASIZE;
  localparam int VW = AW * DW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic w_flush = 1'b0;
  int checks = 0;
  int errors = 0;
  int n;
  int en_cnt;
  int exp_w[5] = '{1, 2, 3, 0, 1};
  logic m_en, w_en, m_busy, w_busy;
  logic [VW-1:0] m_in, w_in;
  logic [DW-1:0] m_max, w_max;
  logic [15:0] m_cnt;
  logic [1:0] w_cnt;
  always #5 clk = ~clk;
  sort_sequencer_if m ();
  sort_sequencer_if w ();
  sort_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(m),
    .sort_en(m_en), .sort_in(m_in), .sort_max(m_max), .busy(m_busy), .job_cnt(m_cnt)
  );
  sort_sequencer #(.CNTW(2)) dut_w (
    .clk(clk), .rst(rst), .flush(w_flush), .bus(w),
    .sort_en(w_en), .sort_in(w_in), .sort_max(w_max), .busy(w_busy), .job_cnt(w_cnt)
  );
  function automatic logic [DW-1:0] vmax(input logic [VW-1:0] v);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < AW; i++) if (v[i*DW +: DW] > r) r = v[i*DW +: DW];
    return r;
  endfunction
  // sorter stand-in: max_out follows the vector while enabled, holds otherwise
  always @(posedge clk) begin
    if (m_en) m_max <= vmax(m_in);
    if (w_en) w_max <= vmax(w_in);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_res(input bit wide, output int cyc);
    cyc = 0;
    while (!(wide ? w.res_valid : m.res_valid) && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask
  task automatic run_job(input string tag, input logic [VW-1:0] d, input logic [DW-1:0] mx, input int cnt);
    int c;
    m.req_valid = 1'b1;
    m.req_data = d;
    tick();
    m.req_valid = 1'b0;
    wait_res(1'b0, c);
    chk({tag, "_lat"}, c, 7);
    chk({tag, "_max"}, m.res_max, mx);
    tick();
    chk({tag, "_cnt"}, m_cnt, cnt);
    chk({tag, "_idle"}, m.res_valid, 0);
  endtask
  initial begin
    m.req_valid = 1'b0; m.req_data = '0; m.res_ready = 1'b1;
    w.req_valid = 1'b0; w.req_data = '0; w.res_ready = 1'b1;
    tick();
    tick();
    chk("rst_ready", m.req_ready, 1);
    chk("rst_en", m_en, 0);
    chk("rst_in", m_in, 0);
    chk("rst_valid", m.res_valid, 0);
    chk("rst_max", m.res_max, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_cnt", m_cnt, 0);
    rst = 1'b0;
    tick();
    m.req_valid = 1'b1;
    m.req_data = 32'h05_2A_11_03;
    tick();
    m.req_valid = 1'b0;
    m.req_data = 32'hDEAD_BEEF;
    chk("t1_en", m_en, 1);
    chk("t1_in", m_in, 32'h05_2A_11_03);
    chk("t1_busy", m_busy, 1);
    chk("t1_ready", m.req_ready, 0);
    en_cnt = 1;
    n = 0;
    while (!m.res_valid && n < 20) begin
      tick();
      n++;
      if (m_en) en_cnt++;
    end
    chk("t1_lat", n, 7);
    chk("t1_en_len", en_cnt, 5);
    chk("t1_max", m.res_max, 8'h2A);
    tick();
    chk("t1_valid_drop", m.res_valid, 0);
    chk("t1_cnt", m_cnt, 1);
    chk("t1_idle", m.req_ready, 1);
    m.res_ready = 1'b0;
    m.req_valid = 1'b1;
    m.req_data = 32'h10_20_30_40;
    tick();
    m.req_valid = 1'b0;
    wait_res(1'b0, n);
    chk("t2_lat", n, 7);
    m.req_valid = 1'b1;
    m.req_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_hold_valid", m.res_valid, 1);
      chk("t2_hold_max", m.res_max, 8'h40);
      chk("t2_hold_ready", m.req_ready, 0);
    end
    m.req_valid = 1'b0;
    m.res_ready = 1'b1;
    tick();
    chk("t2_valid_drop", m.res_valid, 0);
    chk("t2_cnt", m_cnt, 2);
    chk("t2_busy", m_busy, 0);
    chk("t2_in_kept", m_in, 32'h10_20_30_40);
    run_job("t3a", 32'hFF_01_02_03, 8'hFF, 3);
    run_job("t3b", 32'h00_00_00_00, 8'h00, 4);
    run_job("t3c", 32'h12_7F_00_33, 8'h7F, 5);
    m.req_valid = 1'b1;
    m.req_data = 32'h44_55_66_77;
    tick();
    m.req_valid = 1'b0;
    tick();
    chk("t4_run", m_en, 1);
    flush = 1'b1;
    m.req_valid = 1'b1;
    m.req_data = 32'hAAAA_AAAA;
    tick();
    chk("t4_en", m_en, 0);
    chk("t4_busy", m_busy, 0);
    chk("t4_ready_flush", m.req_ready, 0);
    tick();
    chk("t4_no_accept", m_busy, 0);
    flush = 1'b0;
    m.req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m.res_valid) n++;
    end
    chk("t4_no_result", n, 0);
    chk("t4_cnt", m_cnt, 5);
    run_job("t4_new", 32'h01_02_03_04, 8'h04, 6);
    m.req_valid = 1'b1;
    m.req_data = 32'h99_88_77_66;
    tick();
    m.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_settle_en", m_en, 0);
    chk("t5_settle_busy", m_busy, 1);
    chk("t5_settle_valid", m.res_valid, 0);
    rst = 1'b1;
    tick();
    chk("t5_en", m_en, 0);
    chk("t5_in", m_in, 0);
    chk("t5_valid", m.res_valid, 0);
    chk("t5_max", m.res_max, 0);
    chk("t5_busy", m_busy, 0);
    chk("t5_ready", m.req_ready, 1);
    chk("t5_cnt", m_cnt, 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m.res_valid) n++;
    end
    chk("t5_no_result", n, 0);
    for (int j = 0; j < 5; j++) begin
      w.req_valid = 1'b1;
      w.req_data = 32'h01_02_03_00 + 32'(j);
      tick();
      w.req_valid = 1'b0;
      wait_res(1'b1, n);
      chk("t6_lat", n, 7);
      tick();
      chk("t6_cnt", w_cnt, exp_w[j]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
